// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_send transmitter among NUM_REQ requesters.
// Optional busy-rise timeout in ACK is enabled with `define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATAWIDTH  = 16,
  parameter int GAP_CYCLES = 16,
  parameter int BUSY_WAIT  = 8
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           uart_en,
  output logic [DATAWIDTH-1:0]           uart_din,
  input  logic                           uart_tx_busy,
  output logic [15:0]                    frame_cnt,
  output logic                           tx_err
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK  = 2'd1;
  localparam logic [1:0] S_XMIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]           state_q,     state_d;
  logic [PTR_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [NUM_REQ-1:0]   grant_q,     grant_d;
  logic [NUM_REQ-1:0]   done_q,      done_d;
  logic                 uart_en_q,   uart_en_d;
  logic [DATAWIDTH-1:0] uart_din_q,  uart_din_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q,   gap_cnt_d;

  logic                 pick_vld_s;
  logic [PTR_W-1:0]     pick_idx_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W:0]       cand_s;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int BW_W = $clog2(BUSY_WAIT + 1);
  logic [BW_W-1:0]      busy_cnt_q,  busy_cnt_d;
  logic                 tx_err_q,    tx_err_d;
`endif

  // Descending scan so the set bit closest to rr_ptr (smallest offset) is written last and wins
  always_comb begin
    pick_vld_s = 1'b0;
    pick_idx_s = '0;
    sum_s      = '0;
    cand_s     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum_s  = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      cand_s = (sum_s >= (PTR_W+1)'(NUM_REQ)) ? (sum_s - (PTR_W+1)'(NUM_REQ)) : sum_s;
      if (req[cand_s[PTR_W-1:0]]) begin
        pick_vld_s = 1'b1;
        pick_idx_s = cand_s[PTR_W-1:0];
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Sequencer next-state logic
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    done_d      = '0;
    uart_en_d   = uart_en_q;
    uart_din_d  = uart_din_q;
    frame_cnt_d = frame_cnt_q;
    gap_cnt_d   = gap_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    busy_cnt_d  = busy_cnt_q;
    tx_err_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!uart_tx_busy && pick_vld_s) begin
          grant_d    = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
          uart_din_d = req_data[int'(pick_idx_s) * DATAWIDTH +: DATAWIDTH];
          uart_en_d  = 1'b1;
          rr_ptr_d   = (pick_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : (pick_idx_s + PTR_W'(1));
          state_d    = S_ACK;
`ifdef UART_ARB_TIMEOUT_EN
          busy_cnt_d = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        if (uart_tx_busy) begin
          uart_en_d = 1'b0;
          state_d   = S_XMIT;
        end else begin
`ifdef UART_ARB_TIMEOUT_EN
          // Abort without counting a frame; rr_ptr has already moved past this requester
          if (busy_cnt_q == BW_W'(BUSY_WAIT - 1)) begin
            uart_en_d = 1'b0;
            tx_err_d  = 1'b1;
            done_d    = grant_q;
            grant_d   = '0;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            busy_cnt_d = busy_cnt_q + BW_W'(1);
          end
`else
          state_d = S_ACK;
`endif
        end
      end
      S_XMIT: begin
        if (!uart_tx_busy) begin
          done_d      = grant_q;
          grant_d     = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else begin
          state_d = S_XMIT;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d   = S_IDLE;
        grant_d   = '0;
        uart_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      uart_en_q   <= 1'b0;
      uart_din_q  <= '0;
      frame_cnt_q <= 16'd0;
      gap_cnt_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      busy_cnt_q  <= '0;
      tx_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      uart_en_q   <= uart_en_d;
      uart_din_q  <= uart_din_d;
      frame_cnt_q <= frame_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      busy_cnt_q  <= busy_cnt_d;
      tx_err_q    <= tx_err_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign uart_en   = uart_en_q;
  assign uart_din  = uart_din_q;
  assign frame_cnt = frame_cnt_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign tx_err    = tx_err_q;
`else
  assign tx_err    = 1'b0;
`endif

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter and sequencer sharing one uart_send transmitter among NUM_REQ requesters. Each requester presents a DATAWIDTH-bit word. The arbiter grants one requester and launches the transmitter with a clean uart_en rising edge. It tracks uart_tx_busy to completion, then enforces an inter-frame guard gap before the next grant. Sits between the application-side message sources and the uart_send instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATAWIDTH, 16, word width; must equal the uart_send DATAWIDTH
GAP_CYCLES, 16, idle sys_clk cycles between a transfer ending and the next grant (>=2)
BUSY_WAIT, 8, max cycles to wait for uart_tx_busy to rise after uart_en (used only with the optional feature)

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester request level; held high until the matching done pulse
req_data  in  NUM_REQ*DATAWIDTH  word for requester i at bits [i*DATAWIDTH +: DATAWIDTH]
grant  out  NUM_REQ  one-hot; high from grant until the done pulse
done  out  NUM_REQ  one-cycle pulse to the granted requester when its transfer completes
uart_en  out  1  launch level to uart_send (rising edge starts a transfer)
uart_din  out  DATAWIDTH  word to uart_send; registered and stable for the whole transfer
uart_tx_busy  in  1  busy flag from uart_send
frame_cnt  out  16  count of completed transfers; wraps 0xFFFF->0
tx_err  out  1  one-cycle abort pulse (optional feature only; otherwise constant 0)

Behaviour:
- Reset values: grant=0, done=0, uart_en=0, uart_din=0, frame_cnt=0, tx_err=0, state=IDLE, rr_ptr=0.
- States: IDLE, ACK, XMIT, GAP.
- IDLE:
  - If uart_tx_busy=1, wait.
  - Else if any req bit is set, select the first set bit searching from rr_ptr upward with wrap.
  - Next cycle: grant[k]=1, uart_din=req_data slice k, uart_en=1, rr_ptr=(k+1) mod NUM_REQ, go to ACK.
  - Latency: req high in IDLE -> grant/uart_en high 1 cycle later.
- ACK:
  - uart_en stays 1 until uart_tx_busy=1 is sampled.
  - Then uart_en=0 and go to XMIT.
- XMIT:
  - Wait for uart_tx_busy=0.
  - On that cycle: done[k] pulses 1 cycle, grant clears, frame_cnt increments, go to GAP.
- GAP:
  - Count GAP_CYCLES cycles with uart_en=0, then go to IDLE.
  - GAP_CYCLES>=2 guarantees uart_en is low long enough for the uart_send edge detector to re-arm.
- Requests:
  - req deasserted mid-transfer: ignored; the transfer completes and done still pulses.
  - req still high after done: treated as a new request, eligible after GAP.
  - A requester pulled low while ungranted is simply skipped.
- Simultaneous requests are resolved purely by rr_ptr. No requester is granted twice while another is waiting.
- req_data is sampled only in the IDLE->ACK transition; later changes do not affect uart_din.
- uart_din holds its value after the transfer until the next grant.
- Reset mid-operation returns everything to reset values immediately. uart_en dropping to 0 is acceptable; uart_send is reset by the same domain.

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined: in ACK, a counter runs from 0. If uart_tx_busy has not risen after BUSY_WAIT cycles:
  - uart_en=0, tx_err pulses 1 cycle, done[k] pulses on the same cycle, grant clears.
  - frame_cnt is not incremented; go to GAP.
  - rr_ptr already advanced, so the failing requester does not monopolise the transmitter.
- Not defined: ACK waits indefinitely, tx_err is tied to 0, and no timeout counter is synthesised.

Test Plan:
1. Single request: req=4'b0001, req_data[15:0]=16'hA55A -> grant=0001 and uart_en=1 one cycle later, uart_din=16'hA55A; uart_en drops after busy rises; done[0] pulses once when busy falls; frame_cnt=1.
2. Round-robin: req=4'b1111 held continuously with distinct words 0x1111/0x2222/0x3333/0x4444 -> grant order 0,1,2,3,0; gap between done and the next uart_en rise is GAP_CYCLES+1 cycles; transmitted words appear in that order.
3. Pointer fairness: after requester 2 is served, req=4'b0101 -> requester 0 is granted (search wraps from rr_ptr=3), then requester 2.
4. Drop/change mid-transfer: requester 1 granted, then req[1]=0 and req_data changed during XMIT -> the serial stream still carries the originally latched word; done[1] pulses; no regrant of 1.
5. Busy stuck low with UART_ARB_TIMEOUT_EN defined, BUSY_WAIT=8 -> tx_err and done[k] pulse 8 cycles after the uart_en rise; frame_cnt unchanged; without the macro, the arbiter remains in ACK with uart_en=1.
6. Reset during XMIT: assert sys_rst mid-byte -> all outputs return to reset values asynchronously; after release, req=4'b0010 is granted first (rr_ptr=0 search).
